// File: rtl/enc8to3_serializer.sv
// rtl/enc8to3_serializer.sv - multi-hot 8-bit vector to serial 3-bit index beats
// Accepts one vector in IDLE, then emits one index per transfer while in SCAN.
module enc8to3_serializer #(
  parameter int N         = 8,
  parameter int W         = 3,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_vld,
  input  logic [N-1:0] in,
  output logic         in_rdy,
  output logic [W-1:0] out,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic         out_last,
  output logic         err_zero,
  output logic         busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state, state_nxt;
  logic [N-1:0]   pend, pend_nxt, sel_mask;
  logic [W-1:0]   idx;
  logic           single, can_accept, accept_zero;

  // Priority pick: the last match written wins, so scan direction sets the order.
  always_comb begin
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--)
        if (pend[i]) idx = W'(i);
    end else begin
      for (int i = 0; i < N; i++)
        if (pend[i]) idx = W'(i);
    end
  end

  assign sel_mask   = ONE << idx;
  assign single     = (pend != '0) && ((pend & (pend - ONE)) == '0);
  assign can_accept = (state == IDLE) && en;
  assign accept_zero = can_accept && in_vld && (in == '0);

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        // rst_n gate keeps in_rdy low while reset is held; flops never see it.
        in_rdy = can_accept && rst_n;
        if (can_accept && in_vld && (in != '0)) begin
          pend_nxt  = in;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy    = 1'b1;
        out_vld = en;
        if (en && out_rdy) begin
          pend_nxt = pend & ~sel_mask;
          if (single) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out      = idx;
  assign out_last = out_vld && single;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend     <= '0;
      err_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend     <= pend_nxt;
      err_zero <= accept_zero;
    end
  end

endmodule

// File: tb/tb_enc8to3_serializer.sv
// tb/tb_enc8to3_serializer.sv - scoreboard bench for both emission orders
// One instance per LSB_FIRST setting, sharing stimulus; beats are checked against queued indices.
module tb_enc8to3_serializer;

  logic       clk = 1'b0;
  logic       rst_n, en, in_vld, out_rdy;
  logic [7:0] in;
  logic       rdy_l, vld_l, last_l, err_l, busy_l;
  logic       rdy_m, vld_m, last_m, err_m, busy_m;
  logic [2:0] out_l, out_m;

  int errors = 0;
  int checks = 0;

  logic [2:0] q_idx_l[$], q_idx_m[$];
  logic       q_last_l[$], q_last_m[$];
  logic [7:0] recon_l, recon_m;

  always #5 clk = ~clk;

  enc8to3_serializer #(.N(8), .W(3), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .en(en), .in_vld(in_vld), .in(in), .in_rdy(rdy_l),
    .out(out_l), .out_vld(vld_l), .out_rdy(out_rdy), .out_last(last_l),
    .err_zero(err_l), .busy(busy_l));

  enc8to3_serializer #(.N(8), .W(3), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .en(en), .in_vld(in_vld), .in(in), .in_rdy(rdy_m),
    .out(out_m), .out_vld(vld_m), .out_rdy(out_rdy), .out_last(last_m),
    .err_zero(err_m), .busy(busy_m));

  function automatic logic [7:0] dec3to8(input logic [2:0] idx);
    logic [7:0] one;
    one = 8'h01;
    return one << idx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input logic [7:0] v);
    int cnt, seen;
    cnt = $countones(v);
    seen = 0;
    for (int i = 0; i < 8; i++) if (v[i]) begin
      seen++;
      q_idx_l.push_back(3'(i));
      q_last_l.push_back(seen == cnt);
    end
    seen = 0;
    for (int i = 7; i >= 0; i--) if (v[i]) begin
      seen++;
      q_idx_m.push_back(3'(i));
      q_last_m.push_back(seen == cnt);
    end
  endtask

  task automatic tick(input bit want_vld);
    @(negedge clk);
    if (want_vld) begin
      chk("stream_vld_l", {31'd0, vld_l}, 32'd1);
      chk("stream_vld_m", {31'd0, vld_m}, 32'd1);
    end
    if (vld_l && out_rdy) begin
      if (q_idx_l.size() == 0) chk("extra_beat_l", {29'd0, out_l}, 32'hFFFF);
      else begin
        chk("idx_l", {29'd0, out_l}, {29'd0, q_idx_l.pop_front()});
        chk("last_l", {31'd0, last_l}, {31'd0, q_last_l.pop_front()});
        recon_l |= dec3to8(out_l);
      end
    end
    if (vld_m && out_rdy) begin
      if (q_idx_m.size() == 0) chk("extra_beat_m", {29'd0, out_m}, 32'hFFFF);
      else begin
        chk("idx_m", {29'd0, out_m}, {29'd0, q_idx_m.pop_front()});
        chk("last_m", {31'd0, last_m}, {31'd0, q_last_m.pop_front()});
        recon_m |= dec3to8(out_m);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    in_vld = 1'b1;
    in     = v;
    recon_l = '0;
    recon_m = '0;
    @(negedge clk);
    chk("accept_rdy_l", {31'd0, rdy_l}, 32'd1);
    chk("accept_rdy_m", {31'd0, rdy_m}, 32'd1);
    push_model(v);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    in     = 8'h5A;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q_idx_l.size() > 0 || q_idx_m.size() > 0) && n < budget) begin
      tick(1'b1);
      n++;
    end
    chk("drain_done", q_idx_l.size() + q_idx_m.size(), 32'd0);
  endtask

  task automatic expect_idle();
    @(negedge clk);
    chk("idle_rdy_l", {31'd0, rdy_l}, 32'd1);
    chk("idle_rdy_m", {31'd0, rdy_m}, 32'd1);
    chk("idle_busy", {30'd0, busy_l, busy_m}, 32'd0);
    chk("idle_vld", {30'd0, vld_l, vld_m}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk(tag, {18'd0, rdy_l, out_l, vld_l, last_l, err_l, busy_l,
                     rdy_m, out_m, vld_m, last_m, err_m, busy_m}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_vld = 1'b0; out_rdy = 1'b1; in = 8'h00;
    recon_l = '0; recon_m = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    expect_idle();

    // 1001_0110 streamed with out_rdy held high
    send(8'b1001_0110);
    drain(10);
    chk("recon_l_96", {24'd0, recon_l}, 32'h96);
    chk("recon_m_96", {24'd0, recon_m}, 32'h96);
    expect_idle();

    // single bit held under backpressure
    out_rdy = 1'b0;
    send(8'h80);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_l", {27'd0, vld_l, last_l, out_l}, {27'd0, 2'b11, 3'd7});
      chk("bp_hold_m", {27'd0, vld_m, last_m, out_m}, {27'd0, 2'b11, 3'd7});
      @(posedge clk);
      #1;
    end
    out_rdy = 1'b1;
    drain(3);
    chk("recon_80", {16'd0, recon_l, recon_m}, 32'h8080);
    expect_idle();

    // all-zero vector
    send(8'h00);
    @(negedge clk);
    chk("zero_err", {30'd0, err_l, err_m}, 32'd3);
    chk("zero_vld", {30'd0, vld_l, vld_m}, 32'd0);
    chk("zero_rdy", {30'd0, rdy_l, rdy_m}, 32'd3);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("zero_err_pulse", {30'd0, err_l, err_m}, 32'd0);
    @(posedge clk);
    #1;

    // 8'hFF with enable dropped after the third beat
    send(8'hFF);
    for (int i = 0; i < 3; i++) tick(1'b1);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("en_low_l", {26'd0, vld_l, last_l, busy_l, out_l}, {26'd0, 3'b001, 3'd3});
      chk("en_low_m", {26'd0, vld_m, last_m, busy_m, out_m}, {26'd0, 3'b001, 3'd4});
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    drain(8);
    chk("recon_ff", {16'd0, recon_l, recon_m}, 32'hFFFF);
    expect_idle();

    // asynchronous reset in the middle of 8'hF0
    send(8'hF0);
    for (int i = 0; i < 2; i++) tick(1'b1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midscan_reset");
    q_idx_l.delete(); q_last_l.delete();
    q_idx_m.delete(); q_last_m.delete();
    #1;
    rst_n = 1'b1;
    expect_idle();
    send(8'h01);
    @(negedge clk);
    chk("one_beat_l", {27'd0, vld_l, last_l, out_l}, {27'd0, 2'b11, 3'd0});
    chk("one_beat_m", {27'd0, vld_m, last_m, out_m}, {27'd0, 2'b11, 3'd0});
    @(posedge clk);
    #1;
    q_idx_l.delete(); q_last_l.delete();
    q_idx_m.delete(); q_last_m.delete();
    expect_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
